// File: rtl/regfile_fwd_param.sv
// Multi-port register file for the ID stage: NRD combinational read ports with
// an NFWD-deep forwarding network, a byte-masked write port, a dedicated link
// port, load-use stall detection, a prescaled timer register and a saturating
// stall-cycle counter.
module regfile_fwd_param #(
  parameter int unsigned DW       = 32,
  parameter int unsigned AW       = 5,
  parameter int unsigned NRD      = 2,
  parameter int unsigned NFWD     = 3,
  parameter int unsigned NLOAD    = 1,
  parameter int unsigned LINK_REG = 31,
  parameter int unsigned TMR_REG  = 30,
  parameter int unsigned PSC_W    = 20,
  parameter int unsigned SCNT_W   = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                we_i,
  input  logic [AW-1:0]       w_addr_i,
  input  logic [DW-1:0]       w_data_i,
  input  logic [DW/8-1:0]     w_be_i,
  input  logic [NRD-1:0]      rd_en_i,
  input  logic [NRD*AW-1:0]   rd_addr_i,
  output logic [NRD*DW-1:0]   rd_data_o,
  input  logic [NFWD-1:0]     fwd_we_i,
  input  logic [NFWD*AW-1:0]  fwd_addr_i,
  input  logic [NFWD*DW-1:0]  fwd_data_i,
  input  logic [NFWD-1:0]     fwd_load_i,
  input  logic                link_we_i,
  input  logic [DW-1:0]       link_data_i,
  input  logic                tmr_en_i,
  output logic                pause_o,
  output logic [SCNT_W-1:0]   stall_cnt_o
);

  localparam int unsigned Depth = 2 ** AW;
  localparam int unsigned NB    = DW / 8;
  localparam logic [AW-1:0] LinkAddr = AW'(LINK_REG);
  localparam logic [AW-1:0] TmrAddr  = AW'(TMR_REG);

  logic [DW-1:0]     regs_q [Depth];
  logic [DW-1:0]     regs_d [Depth];
  logic [PSC_W-1:0]  psc_q, psc_d;
  logic [SCNT_W-1:0] stall_q, stall_d;
  logic [NRD-1:0]    hazard;

  logic wr_ok, wr_tmr, tmr_tick;

  // Only stages below NLOAD can raise a load-use hazard; the rest are don't-care.
  logic unused_fwd_load;
  assign unused_fwd_load = ^fwd_load_i;

  // A write with no byte lanes enabled is a no-op, so it must not block the timer.
  assign wr_ok    = we_i && (w_addr_i != '0) && (w_addr_i != LinkAddr) && (|w_be_i);
  assign wr_tmr   = wr_ok && (w_addr_i == TmrAddr);
  assign tmr_tick = tmr_en_i && (psc_q == '1);

  // Per-port forwarding mux and hazard detection.
  for (genvar p = 0; p < NRD; p++) begin : g_rd
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          hit;
    logic          haz;

    assign addr = rd_addr_i[p*AW +: AW];

    // First matching stage (youngest first) wins; r0 is hard-wired to zero.
    always_comb begin
      data = regs_q[addr];
      hit  = 1'b0;
      for (int unsigned k = 0; k < NFWD; k++) begin
        if (!hit && fwd_we_i[k] && (fwd_addr_i[k*AW +: AW] == addr)) begin
          data = fwd_data_i[k*DW +: DW];
          hit  = 1'b1;
        end
      end
      if (addr == '0) data = '0;
    end

    // Load result still in flight for a register this port actually needs.
    always_comb begin
      haz = 1'b0;
      for (int unsigned k = 0; k < NLOAD; k++) begin
        if (fwd_we_i[k] && fwd_load_i[k] && (fwd_addr_i[k*AW +: AW] == addr)) haz = 1'b1;
      end
      if (!rd_en_i[p] || (addr == '0)) haz = 1'b0;
    end

    assign rd_data_o[p*DW +: DW] = data;
    assign hazard[p]             = haz;
  end

  assign pause_o     = |hazard;
  assign stall_cnt_o = stall_q;

  // Next register-file contents: timer tick, byte write, link write, r0 clamp.
  always_comb begin
    regs_d = regs_q;
    if (tmr_tick && !wr_tmr) regs_d[TmrAddr] = regs_q[TmrAddr] + DW'(1);
    if (wr_ok) begin
      for (int unsigned i = 0; i < NB; i++) begin
        if (w_be_i[i]) regs_d[w_addr_i][8*i +: 8] = w_data_i[8*i +: 8];
      end
    end
    if (link_we_i) regs_d[LinkAddr] = link_data_i;
    regs_d[0] = '0;
  end

  // Prescaler and saturating stall counter next state.
  always_comb begin
    psc_d   = tmr_en_i ? psc_q + PSC_W'(1) : psc_q;
    stall_d = (pause_o && (stall_q != '1)) ? stall_q + SCNT_W'(1) : stall_q;
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      regs_q  <= '{default: '0};
      psc_q   <= '0;
      stall_q <= '0;
    end else begin
      regs_q  <= regs_d;
      psc_q   <= psc_d;
      stall_q <= stall_d;
    end
  end

endmodule

// File: tb/tb_regfile_fwd_param.sv
// Self-checking bench for regfile_fwd_param: table-driven forwarding / stall
// vectors plus hand-written sequences for writes, timer, link, saturation and reset.
module tb_regfile_fwd_param;

  logic         clk = 1'b0;
  logic         rst;
  logic         we;
  logic [4:0]   w_addr;
  logic [31:0]  w_data;
  logic [3:0]   w_be;
  logic [1:0]   rd_en;
  logic [9:0]   rd_addr;
  logic [63:0]  rd_data;
  logic [2:0]   fwd_we;
  logic [14:0]  fwd_addr;
  logic [95:0]  fwd_data;
  logic [2:0]   fwd_load;
  logic         link_we;
  logic [31:0]  link_data;
  logic         tmr_en;
  logic         pause;
  logic [3:0]   stall_cnt;

  regfile_fwd_param #(
    .DW(32), .AW(5), .NRD(2), .NFWD(3), .NLOAD(1),
    .LINK_REG(31), .TMR_REG(30), .PSC_W(2), .SCNT_W(4)
  ) dut (
    .clk_i(clk), .rst_i(rst), .we_i(we), .w_addr_i(w_addr), .w_data_i(w_data),
    .w_be_i(w_be), .rd_en_i(rd_en), .rd_addr_i(rd_addr), .rd_data_o(rd_data),
    .fwd_we_i(fwd_we), .fwd_addr_i(fwd_addr), .fwd_data_i(fwd_data),
    .fwd_load_i(fwd_load), .link_we_i(link_we), .link_data_i(link_data),
    .tmr_en_i(tmr_en), .pause_o(pause), .stall_cnt_o(stall_cnt)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    string       name;
    logic [31:0] exp;
  } sb_t;
  sb_t sb_q[$];

  typedef struct {
    logic [2:0]  fwe;
    logic [14:0] fa;
    logic [95:0] fd;
    logic [2:0]  fld;
    logic [1:0]  ren;
    logic [4:0]  r0;
    logic [4:0]  r1;
    logic [31:0] e0;
    logic [31:0] e1;
    logic        ep;
  } vec_t;
  vec_t vt[11];

  int stall_exp = 0;

  task automatic sb_push(input string name, input logic [31:0] exp);
    sb_t e;
    e.name = name;
    e.exp  = exp;
    sb_q.push_back(e);
  endtask

  task automatic sb_pop(input logic [31:0] act);
    sb_t e;
    n_chk++;
    if (sb_q.size() == 0) begin
      n_fail++;
      $display("FAIL scoreboard_empty actual=%h", act);
    end else begin
      e = sb_q.pop_front();
      if (act !== e.exp) begin
        n_fail++;
        $display("FAIL %s actual=%h required=%h", e.name, act, e.exp);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd_chk(input string name, input logic [4:0] a, input logic [31:0] exp);
    rd_addr[4:0] = a;
    sb_push(name, exp);
    #1;
    sb_pop(rd_data[31:0]);
  endtask

  task automatic stall_chk(input string name, input int exp);
    sb_push(name, 32'(exp));
    sb_pop(32'(stall_cnt));
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
    we = 1'b1; w_addr = a; w_data = d; w_be = be;
    tick();
    we = 1'b0; w_be = 4'h0;
  endtask

  task automatic clr_fwd();
    fwd_we = '0; fwd_addr = '0; fwd_data = '0; fwd_load = '0; rd_en = '0;
  endtask

  initial begin
    rst = 1'b1; we = 1'b0; w_addr = '0; w_data = '0; w_be = '0;
    rd_addr = '0; link_we = 1'b0; link_data = '0; tmr_en = 1'b0;
    clr_fwd();

    // Reset state
    repeat (2) tick();
    rd_addr = {5'd30, 5'd5};
    sb_push("reset_rd0", 32'h0);
    sb_push("reset_rd1", 32'h0);
    sb_push("reset_pause", 32'h0);
    #1;
    sb_pop(rd_data[31:0]);
    sb_pop(rd_data[63:32]);
    sb_pop({31'b0, pause});
    stall_chk("reset_stall", 0);
    rst = 1'b0;
    tick();

    wr(5'd3, 32'h99, 4'hf);
    wr(5'd4, 32'hAABBCCDD, 4'hf);
    wr(5'd7, 32'h77, 4'hf);
    wr(5'd9, 32'h1234, 4'hf);
    rd_chk("preload_r3", 5'd3, 32'h99);

    // Forwarding priority and load-use vectors
    vt[0]  = '{3'b101, {5'd3, 5'd0, 5'd3}, {32'h33, 32'h0, 32'h11}, 3'b000, 2'b00,
               5'd3, 5'd4, 32'h11, 32'hAABBCCDD, 1'b0};
    vt[1]  = '{3'b100, {5'd3, 5'd0, 5'd3}, {32'h33, 32'h0, 32'h11}, 3'b000, 2'b00,
               5'd3, 5'd4, 32'h33, 32'hAABBCCDD, 1'b0};
    vt[2]  = '{3'b000, {5'd3, 5'd0, 5'd3}, {32'h33, 32'h0, 32'h11}, 3'b000, 2'b00,
               5'd3, 5'd4, 32'h99, 32'hAABBCCDD, 1'b0};
    vt[3]  = '{3'b001, {5'd0, 5'd0, 5'd0}, {32'h0, 32'h0, 32'hDEAD}, 3'b000, 2'b11,
               5'd0, 5'd4, 32'h0, 32'hAABBCCDD, 1'b0};
    vt[4]  = '{3'b001, {5'd0, 5'd0, 5'd7}, {32'h0, 32'h0, 32'h700}, 3'b001, 2'b01,
               5'd7, 5'd9, 32'h700, 32'h1234, 1'b1};
    vt[5]  = '{3'b001, {5'd0, 5'd0, 5'd7}, {32'h0, 32'h0, 32'h700}, 3'b001, 2'b00,
               5'd7, 5'd9, 32'h700, 32'h1234, 1'b0};
    vt[6]  = '{3'b001, {5'd0, 5'd0, 5'd7}, {32'h0, 32'h0, 32'h700}, 3'b001, 2'b10,
               5'd3, 5'd7, 32'h99, 32'h700, 1'b1};
    vt[7]  = '{3'b010, {5'd0, 5'd7, 5'd0}, {32'h0, 32'h7100, 32'h0}, 3'b010, 2'b11,
               5'd7, 5'd3, 32'h7100, 32'h99, 1'b0};
    vt[8]  = '{3'b000, {5'd0, 5'd0, 5'd7}, {32'h0, 32'h0, 32'h700}, 3'b001, 2'b01,
               5'd7, 5'd4, 32'h77, 32'hAABBCCDD, 1'b0};
    vt[9]  = '{3'b001, {5'd0, 5'd0, 5'd0}, {32'h0, 32'h0, 32'hDEAD}, 3'b001, 2'b11,
               5'd0, 5'd0, 32'h0, 32'h0, 1'b0};
    vt[10] = '{3'b111, {5'd3, 5'd4, 5'd9}, {32'h333, 32'h444, 32'h909}, 3'b000, 2'b11,
               5'd4, 5'd3, 32'h444, 32'h333, 1'b0};

    for (int i = 0; i < 11; i++) begin
      tick();
      fwd_we = vt[i].fwe; fwd_addr = vt[i].fa; fwd_data = vt[i].fd;
      fwd_load = vt[i].fld; rd_en = vt[i].ren; rd_addr = {vt[i].r1, vt[i].r0};
      sb_push($sformatf("v%0d_rd0", i), vt[i].e0);
      sb_push($sformatf("v%0d_rd1", i), vt[i].e1);
      sb_push($sformatf("v%0d_pause", i), {31'b0, vt[i].ep});
      #3;
      sb_pop(rd_data[31:0]);
      sb_pop(rd_data[63:32]);
      sb_pop({31'b0, pause});
      if (vt[i].ep && stall_exp < 15) stall_exp++;
    end
    tick();
    clr_fwd();
    stall_chk("stall_after_table", stall_exp);

    // Stall counter saturation
    fwd_we = 3'b001; fwd_load = 3'b001; fwd_addr = {10'd0, 5'd7}; rd_en = 2'b01;
    rd_addr = {5'd0, 5'd7};
    repeat (12) tick();
    stall_chk("stall_14", 14);
    repeat (5) tick();
    stall_chk("stall_sat", 15);
    clr_fwd();
    tick();
    stall_chk("stall_hold", 15);

    // Byte-masked writes and dropped writes
    wr(5'd4, 32'h11223344, 4'b0101);
    rd_chk("byte_write", 5'd4, 32'hAA22CC44);
    wr(5'd4, 32'hFFFFFFFF, 4'b0000);
    rd_chk("be_zero_noop", 5'd4, 32'hAA22CC44);
    wr(5'd0, 32'hCAFEF00D, 4'hf);
    rd_chk("r0_stays_zero", 5'd0, 32'h0);
    wr(5'd31, 32'h5, 4'hf);
    rd_chk("link_reg_write_dropped", 5'd31, 32'h0);

    // Timer with 4-cycle prescale
    tmr_en = 1'b1;
    repeat (8) tick();
    tmr_en = 1'b0;
    rd_chk("timer_8cyc", 5'd30, 32'h2);
    repeat (3) tick();
    rd_chk("timer_frozen", 5'd30, 32'h2);
    tmr_en = 1'b1;
    repeat (3) tick();
    wr(5'd30, 32'h100, 4'hf);
    rd_chk("timer_write_wins", 5'd30, 32'h100);
    repeat (4) tick();
    tmr_en = 1'b0;
    rd_chk("timer_resumes", 5'd30, 32'h101);

    // Link port vs write port to the link register
    link_we = 1'b1; link_data = 32'h400;
    wr(5'd31, 32'h5, 4'hf);
    link_we = 1'b0;
    rd_chk("link_beats_write", 5'd31, 32'h400);
    link_we = 1'b1; link_data = 32'h12345678;
    tick();
    link_we = 1'b0;
    rd_chk("link_alone", 5'd31, 32'h12345678);

    // Asynchronous reset mid-cycle with a write in flight
    tick();
    we = 1'b1; w_addr = 5'd5; w_data = 32'h55; w_be = 4'hf;
    fwd_we = 3'b001; fwd_load = 3'b001; fwd_addr = {10'd0, 5'd7}; rd_en = 2'b01;
    rd_addr = {5'd0, 5'd7};
    #1;
    clr_fwd();
    rst = 1'b1;
    rd_addr = {5'd31, 5'd4};
    sb_push("midrst_r4", 32'h0);
    sb_push("midrst_r31", 32'h0);
    #1;
    sb_pop(rd_data[31:0]);
    sb_pop(rd_data[63:32]);
    stall_chk("midrst_stall", 0);
    tick();
    we = 1'b0; w_be = 4'h0;
    tick();
    rst = 1'b0;
    rd_chk("post_reset_r5", 5'd5, 32'h0);
    wr(5'd5, 32'h5A, 4'hf);
    rd_chk("first_write_after_reset", 5'd5, 32'h5A);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
